apb_master_q: RTL and testbench

//  Queued, multi-slave APB4 master; successor to the single-request, single-slave APB master.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_req_fifo.sv | 51 +++++
 rtl/apb_master_q.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_q.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the queued APB4 master: FSM states and the request payload.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                  rd0_wr1;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module apb_req_fifo
    import apb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  apb_req_t         push_data,
    input  logic             pop,
    output apb_req_t         pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    apb_req_t         mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/apb_master_q.sv
// Queued multi-slave APB4 master: request FIFO, address decode, ACCESS timeout
// and registered read/write completion reporting.
module apb_master_q
    import apb_pkg::*;
#(
    parameter  int unsigned ADDR_W     = APB_ADDR_W,
    parameter  int unsigned DATA_W     = APB_DATA_W,
    parameter  int unsigned NUM_SLV    = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned TIMEOUT    = 16,
    localparam int unsigned STRB_W     = DATA_W / 8,
    localparam int unsigned SEL_W      = $clog2(NUM_SLV),
    localparam int unsigned TO_W       = $clog2(TIMEOUT),
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      i_clk_apb,
    input  logic                      i_rst_apb,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_rd0_wr1,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic [STRB_W-1:0]         i_strb,
    output logic                      o_rd_valid,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic                      o_wr_done,
    output logic                      o_resp_err,
    output logic [NUM_SLV-1:0]        o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [ADDR_W-1:0]         o_paddr,
    output logic [DATA_W-1:0]         o_pwdata,
    output logic [STRB_W-1:0]         o_pstrb,
    input  logic [NUM_SLV-1:0]        i_pready,
    input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]        i_pslverr
);

    state_t           state, state_nxt;
    apb_req_t         push_req, head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;

    logic [SEL_W-1:0]   sel_idx, sel_idx_nxt, head_sel;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic [NUM_SLV-1:0] psel_nxt;
    logic               penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [DATA_W-1:0]  pwdata_nxt, rd_data_nxt;
    logic [STRB_W-1:0]  pstrb_nxt;
    logic               rd_valid_nxt, wr_done_nxt, resp_err_nxt;
    logic               load_head, clear_bus;

    logic [DATA_W-1:0]  prdata_arr [NUM_SLV];
    logic               pready_sel, pslverr_sel, to_hit, xfer_done;

    assign push_req = '{rd0_wr1: i_rd0_wr1, addr: i_addr, wdata: i_wr_data, strb: i_strb};
    assign o_ready  = !fifo_full;

    apb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (i_clk_apb),
        .rst       (i_rst_apb),
        .push      (i_valid),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    fifo_count_consistent: assert property (@(posedge i_clk_apb) disable iff (i_rst_apb)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

    // Slave responses are taken only from the slave latched at request load.
    for (genvar s = 0; s < NUM_SLV; s++) begin : g_prdata
        assign prdata_arr[s] = i_prdata[s*DATA_W +: DATA_W];
    end

    assign head_sel    = head.addr[APB_ADDR_W-1 -: SEL_W];
    assign pready_sel  = i_pready[sel_idx];
    assign pslverr_sel = i_pslverr[sel_idx];
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT - 1));
    assign xfer_done   = pready_sel || to_hit;

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (xfer_done) state_nxt = fifo_empty ? IDLE : SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop     = 1'b0;
        load_head    = 1'b0;
        clear_bus    = 1'b0;
        sel_idx_nxt  = sel_idx;
        to_cnt_nxt   = to_cnt;
        psel_nxt     = o_psel;
        penable_nxt  = o_penable;
        pwrite_nxt   = o_pwrite;
        paddr_nxt    = o_paddr;
        pwdata_nxt   = o_pwdata;
        pstrb_nxt    = o_pstrb;
        rd_valid_nxt = 1'b0;
        wr_done_nxt  = 1'b0;
        resp_err_nxt = 1'b0;
        rd_data_nxt  = o_rd_data;
        case (state)
            IDLE: begin
                if (!fifo_empty) load_head = 1'b1;
            end
            SETUP: begin
                penable_nxt = 1'b1;
                to_cnt_nxt  = '0;
            end
            ACCESS: begin
                if (xfer_done) begin
                    penable_nxt  = 1'b0;
                    resp_err_nxt = pready_sel ? pslverr_sel : 1'b1;
                    if (o_pwrite) begin
                        wr_done_nxt = 1'b1;
                    end else begin
                        rd_valid_nxt = 1'b1;
                        rd_data_nxt  = pready_sel ? prdata_arr[sel_idx] : '0;
                    end
                    if (!fifo_empty) load_head = 1'b1;
                    else             clear_bus = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            default: clear_bus = 1'b1;
        endcase

        // Back-to-back loads keep psel asserted; write-only fields read as zero for reads.
        if (load_head) begin
            fifo_pop    = 1'b1;
            sel_idx_nxt = head_sel;
            psel_nxt    = NUM_SLV'(1) << head_sel;
            penable_nxt = 1'b0;
            pwrite_nxt  = head.rd0_wr1;
            paddr_nxt   = head.addr;
            pwdata_nxt  = head.rd0_wr1 ? head.wdata : '0;
            pstrb_nxt   = head.rd0_wr1 ? head.strb  : '0;
        end else if (clear_bus) begin
            psel_nxt    = '0;
            penable_nxt = 1'b0;
            pwrite_nxt  = 1'b0;
            paddr_nxt   = '0;
            pwdata_nxt  = '0;
            pstrb_nxt   = '0;
        end
    end

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            sel_idx    <= '0;
            to_cnt     <= '0;
            o_psel     <= '0;
            o_penable  <= 1'b0;
            o_pwrite   <= 1'b0;
            o_paddr    <= '0;
            o_pwdata   <= '0;
            o_pstrb    <= '0;
            o_rd_valid <= 1'b0;
            o_wr_done  <= 1'b0;
            o_resp_err <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            sel_idx    <= sel_idx_nxt;
            to_cnt     <= to_cnt_nxt;
            o_psel     <= psel_nxt;
            o_penable  <= penable_nxt;
            o_pwrite   <= pwrite_nxt;
            o_paddr    <= paddr_nxt;
            o_pwdata   <= pwdata_nxt;
            o_pstrb    <= pstrb_nxt;
            o_rd_valid <= rd_valid_nxt;
            o_wr_done  <= wr_done_nxt;
            o_resp_err <= resp_err_nxt;
            o_rd_data  <= rd_data_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_q.sv
// Directed bench for apb_master_q: scoreboard of expected completions plus a
// configurable APB slave responder.
module tb_apb_master_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_rd0_wr1;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic [3:0]  i_strb;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_wr_done;
    logic        o_resp_err;
    logic [3:0]  o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic [3:0]  i_pready;
    logic [127:0] i_prdata;
    logic [3:0]  i_pslverr;

    apb_master_q dut (
        .i_clk_apb  (clk),
        .i_rst_apb  (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rd0_wr1  (i_rd0_wr1),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_strb     (i_strb),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_wr_done  (o_wr_done),
        .o_resp_err (o_resp_err),
        .o_psel     (o_psel),
        .o_penable  (o_penable),
        .o_pwrite   (o_pwrite),
        .o_paddr    (o_paddr),
        .o_pwdata   (o_pwdata),
        .o_pstrb    (o_pstrb),
        .i_pready   (i_pready),
        .i_prdata   (i_prdata),
        .i_pslverr  (i_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_stall = 0;

    // Slave model configuration
    logic [31:0] slv_data [4];
    int          wait_cfg = 0;
    bit          never_ready = 0;
    bit          err_cfg = 0;
    bit          stray = 0;
    int          acc_cnt = 0;

    always_comb begin
        for (int s = 0; s < 4; s++) i_prdata[s*32 +: 32] = slv_data[s];
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: stray mode raises PREADY/PSLVERR on every non-selected slave.
    always @(negedge clk) begin
        i_pready  = stray ? ~o_psel : 4'b0000;
        i_pslverr = stray ? ~o_psel : 4'b0000;
        if (o_penable && o_psel != 4'b0000) begin
            if (!never_ready && acc_cnt >= wait_cfg) begin
                i_pready = i_pready | o_psel;
                if (err_cfg) i_pslverr = i_pslverr | o_psel;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
    end

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            chk("pulse_exclusive", 64'(o_rd_valid & o_wr_done), 64'd0);
            if (o_rd_valid || o_wr_done) begin
                exp_t e;
                done_cnt++;
                chk("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_kind_wr", 64'(o_wr_done), 64'(e.wr));
                    if (!e.wr) chk("sb_rd_data", 64'(o_rd_data), 64'(e.data));
                    chk("sb_resp_err", 64'(o_resp_err), 64'(e.err));
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_data, input logic exp_err);
        int n = 0;
        i_valid   = 1'b1;
        i_rd0_wr1 = wr;
        i_addr    = addr;
        i_wr_data = data;
        i_strb    = strb;
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_stall = n;
        if (n >= 200) chk("push_ready_timeout", 64'(n), 64'd0);
        exp_q.push_back('{wr: wr, data: exp_data, err: exp_err});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_psel"},     64'(o_psel), 64'd0);
        chk({tag, "_penable"},  64'(o_penable), 64'd0);
        chk({tag, "_pwrite"},   64'(o_pwrite), 64'd0);
        chk({tag, "_paddr"},    64'(o_paddr), 64'd0);
        chk({tag, "_pwdata"},   64'(o_pwdata), 64'd0);
        chk({tag, "_pstrb"},    64'(o_pstrb), 64'd0);
        chk({tag, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
        chk({tag, "_wr_done"},  64'(o_wr_done), 64'd0);
        chk({tag, "_resp_err"}, 64'(o_resp_err), 64'd0);
        chk({tag, "_rd_data"},  64'(o_rd_data), 64'd0);
        chk({tag, "_ready"},    64'(o_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulse_cyc [$];
        int acc_cycles;
        int done_at;
        bit hold_ok;
        bit gap;
        bit quiet;

        slv_data[0] = 32'h1111_0000;
        slv_data[1] = 32'hCAFE_F00D;
        slv_data[2] = 32'hDEAD_BEEF;
        slv_data[3] = 32'h3333_CCCC;
        rst = 1'b1; i_valid = 1'b0; i_rd0_wr1 = 1'b0;
        i_addr = '0; i_wr_data = '0; i_strb = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single zero-wait read, slave 2; junk write fields must not reach the bus
        push(1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 1'b0);
        i_valid = 1'b0;
        @(negedge clk);
        chk("rd_psel_k1",    64'(o_psel), 64'h4);
        chk("rd_penable_k1", 64'(o_penable), 64'd0);
        chk("rd_paddr",      64'(o_paddr), 64'h8000_0010);
        chk("rd_pwdata_zero", 64'(o_pwdata), 64'd0);
        chk("rd_pstrb_zero", 64'(o_pstrb), 64'd0);
        @(negedge clk);
        chk("rd_penable_k2", 64'(o_penable), 64'd1);
        @(negedge clk);
        chk("rd_valid_k3",   64'(o_rd_valid), 64'd1);
        @(negedge clk);
        chk("rd_valid_pulse_end", 64'(o_rd_valid), 64'd0);
        chk("rd_psel_released",   64'(o_psel), 64'd0);
        chk("rd_data_held",       64'(o_rd_data), 64'hDEAD_BEEF);

        // Write with 3 wait states, slave 0
        wait_cfg = 3;
        push(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 32'h0, 1'b0);
        i_valid = 1'b0;
        hold_ok = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 12 && done_at == 0; i++) begin
            @(negedge clk);
            if (o_wr_done) done_at = i;
            else if (o_psel != 0 &&
                     (o_pstrb != 4'b0011 || o_pwdata != 32'h1234_5678 ||
                      o_psel != 4'b0001 || !o_pwrite || o_paddr != 32'h20))
                hold_ok = 1'b0;
        end
        chk("wr_fields_stable", 64'(hold_ok), 64'd1);
        chk("wr_done_cycle",    64'(done_at), 64'd6);
        chk("wr_pwdata_cleared", 64'(o_pwdata), 64'd0);
        chk("wr_pstrb_cleared",  64'(o_pstrb), 64'd0);
        wait_cfg = 0;
        @(negedge clk);

        // Five back-to-back requests while the first slave stalls
        never_ready = 1'b1;
        push(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h1111_0000, 1'b0);
        chk("fill_stall_0", 64'(last_stall), 64'd0);
        push(1'b1, 32'h4000_0004, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0);
        chk("fill_stall_1", 64'(last_stall), 64'd0);
        push(1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        chk("fill_stall_2", 64'(last_stall), 64'd0);
        push(1'b1, 32'hC000_000C, 32'h0BAD_F00D, 4'b1000, 32'h0, 1'b0);
        chk("fill_stall_3", 64'(last_stall), 64'd0);
        push(1'b0, 32'hC000_0010, 32'h0, 4'h0, 32'h3333_CCCC, 1'b0);
        chk("fill_stall_4", 64'(last_stall), 64'd0);
        i_valid = 1'b0;
        chk("fifo_full_ready_low", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        never_ready = 1'b0;
        begin
            int target = done_cnt + 5;
            int seen = 0;
            gap = 1'b0;
            for (int i = 0; i < 60 && seen < 5; i++) begin
                @(negedge clk);
                if (o_rd_valid || o_wr_done) begin
                    pulse_cyc.push_back(cyc);
                    seen++;
                end
                if (o_psel == 4'b0000 && seen < 5) gap = 1'b1;
            end
            chk("b2b_all_done", 64'(done_cnt >= target), 64'd1);
        end
        chk("b2b_no_idle_gap", 64'(gap), 64'd0);
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk("b2b_pulse_spacing", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'd2);
        chk("b2b_ready_back", 64'(o_ready), 64'd1);
        @(negedge clk);

        // PSLVERR on slave 1 read: data passes through with error flag
        err_cfg = 1'b1;
        push(1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
        i_valid = 1'b0;
        wait_done(done_cnt + 1, "slverr_done");
        err_cfg = 1'b0;
        @(negedge clk);

        // Timeout on slave 3 with stray PREADY elsewhere; queued write then proceeds
        never_ready = 1'b1;
        stray = 1'b1;
        push(1'b0, 32'hC000_0000, 32'h0, 4'h0, 32'h0, 1'b1);
        push(1'b1, 32'h8000_0000, 32'h5A5A_5A5A, 4'b0001, 32'h0, 1'b0);
        i_valid = 1'b0;
        acc_cycles = 0;
        done_at = 0;
        for (int i = 0; i < 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (o_rd_valid) done_at = 1;
            else if (o_penable) acc_cycles++;
        end
        chk("timeout_access_cycles", 64'(acc_cycles), 64'd16);
        chk("timeout_rd_data_zero",  64'(o_rd_data), 64'd0);
        chk("timeout_next_psel",     64'(o_psel), 64'h4);
        never_ready = 1'b0;
        wait_done(done_cnt + 1, "after_timeout_done");
        stray = 1'b0;
        @(negedge clk);

        // Reset during ACCESS with two requests still queued
        never_ready = 1'b1;
        push(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1'b0);
        push(1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'h0, 1'b0);
        push(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b0);
        i_valid = 1'b0;
        chk("midrst_in_access", 64'(o_penable), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        never_ready = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_psel != 0 || o_rd_valid || o_wr_done) quiet = 1'b0;
        end
        chk("midrst_no_activity", 64'(quiet), 64'd1);
        chk("midrst_ready",       64'(o_ready), 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
